// File: rtl/serial_arith_pkg.sv
// Shared encodings for the serial add/subtract datapath and its control FSM.
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_ADD  = 2'b10;
    localparam logic [1:0] ST_FIN  = 2'b11;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_ADD  = ST_ADD,
        S_FIN  = ST_FIN
    } state_t;

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit full adder with its carry flop; the carry is preset at the start
// of an operation (0 for add, 1 for subtract) and updated each enabled edge.
module serial_fa_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic init,
    input  logic init_val,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout,
    output logic cin_q
);

    assign sum  = a ^ b ^ cin_q;
    assign cout = (a & b) | (a & cin_q) | (b & cin_q);

    // carry register: preset on init, otherwise ripple one bit per enabled edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cin_q <= 1'b0;
        else if (init)
            cin_q <= init_val;
        else if (en)
            cin_q <= cout;
    end

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial adder/subtractor: operands captured on start, processed LSB
// first over exactly WIDTH cycles, result committed only on the final bit.
module serial_addsub_unit
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_lat, b_lat;
    logic             mode_lat;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             fa_sum, fa_cout, fa_cin;
    logic             add_en;

    assign add_en  = (state == S_ADD) && !abort;
    assign res_nxt = {fa_sum, res_sr[WIDTH-1:1]};

    serial_fa_bit u_fa (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (state == S_LOAD),
        .init_val (mode_lat),
        .en       (add_en),
        .a        (a_sr[0]),
        .b        (b_sr[0]),
        .sum      (fa_sum),
        .cout     (fa_cout),
        .cin_q    (fa_cin)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // next-state and handshake outputs; abort only matters while busy
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = S_LOAD;
            end
            S_LOAD: begin
                busy      = 1'b1;
                state_nxt = abort ? S_IDLE : S_ADD;
            end
            S_ADD: begin
                busy = 1'b1;
                if (abort)
                    state_nxt = S_IDLE;
                else if (cnt == TERM)
                    state_nxt = S_FIN;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // operand capture, shift registers, bit counter and committed results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lat     <= '0;
            b_lat     <= '0;
            mode_lat  <= MODE_ADD;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_lat    <= a;
                        b_lat    <= b;
                        mode_lat <= mode;
                    end
                end
                S_LOAD: begin
                    // subtract is a + ~b + 1; the +1 comes from the carry preset
                    a_sr <= a_lat;
                    b_sr <= b_lat ^ {WIDTH{mode_lat}};
                    cnt  <= '0;
                end
                S_ADD: begin
                    if (abort) begin
                        cnt <= '0;
                    end else begin
                        a_sr   <= a_sr >> 1;
                        b_sr   <= b_sr >> 1;
                        res_sr <= res_nxt;
                        if (cnt == TERM) begin
                            cnt       <= '0;
                            result    <= res_nxt;
                            carry_out <= fa_cout;
                            overflow  <= fa_cin ^ fa_cout;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Scoreboard bench: the driver pushes model results at each accept edge,
// a negedge monitor pops and compares whenever done pulses.
module tb_serial_addsub_unit;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           dcyc;
    } exp_t;

    logic         clk, rst_n, start, mode, abort;
    logic [W-1:0] a, b;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] result;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_run = 0;
    logic prev_done = 1'b0;

    serial_addsub_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .abort     (abort),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain modular and signed arithmetic
    function automatic exp_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        exp_t e;
        logic [W:0]          s;
        logic signed [W+1:0] sx, sy, sr, maxs, mins;
        sx   = {{2{x[W-1]}}, x};
        sy   = {{2{y[W-1]}}, y};
        maxs = {3'b000, {(W-1){1'b1}}};
        mins = -maxs - 1;
        if (m) begin
            e.res = x - y;
            e.co  = (x >= y);
            sr    = sx - sy;
        end else begin
            s     = {1'b0, x} + {1'b0, y};
            e.res = s[W-1:0];
            e.co  = s[W];
            sr    = sx + sy;
        end
        e.ov   = (sr > maxs) || (sr < mins);
        e.dcyc = 0;
        return e;
    endfunction

    // monitor: compare on each done pulse
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                chk("done_width", {63'b0, prev_done}, 64'd0);
                chk("busy_len", 64'(busy_run), 64'(W + 1));
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done seen with no op pending (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("result", 64'(result), 64'(e.res));
                    chk("carry_out", 64'(carry_out), 64'(e.co));
                    chk("overflow", 64'(overflow), 64'(e.ov));
                    chk("latency", 64'(cyc), 64'(e.dcyc));
                end
            end
            busy_run  = busy ? busy_run + 1 : 0;
            prev_done = done;
        end else begin
            busy_run  = 0;
            prev_done = 1'b0;
        end
    end

    // push expectation for an op accepted at the edge just taken
    task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        exp_t e;
        e = ref_op(x, y, m);
        // start edge counts as the first of WIDTH+2 edges up to done
        e.dcyc = cyc + W + 1;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 4 * (W + 3)) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout_pending", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m, input logic ab);
        @(negedge clk);
        start = 1'b1; a = x; b = y; mode = m; abort = ab;
        @(posedge clk);
        #1 push_exp(x, y, m);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
        wait_idle();
    endtask

    initial begin
        exp_t keep;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_carry", 64'(carry_out), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed corners
        do_op(W'(8'h3C), W'(8'h05), 1'b0, 1'b0);
        do_op(W'(8'h05), W'(8'h07), 1'b1, 1'b0);
        do_op(W'(8'h80), W'(8'h01), 1'b1, 1'b0);
        do_op(W'(8'h7F), W'(8'h01), 1'b0, 1'b0);
        do_op(W'(8'hFF), W'(8'h01), 1'b0, 1'b0);
        // abort together with start in IDLE: start still accepted
        do_op(W'(8'h55), W'(8'hAA), 1'b1, 1'b1);

        // random ops
        for (int i = 0; i < 16; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);

        // start held high with operands changing every cycle
        for (int k = 0; k < 4 * (W + 3); k++) begin
            @(negedge clk);
            start = 1'b1; a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
            @(posedge clk);
            #1 if (k % (W + 3) == 0) push_exp(a, b, mode);
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // abort on the 3rd ADD cycle: no done, previous result kept
        do_op(W'(8'h10), W'(8'h20), 1'b0, 1'b0);
        keep = ref_op(W'(8'h10), W'(8'h20), 1'b0);
        @(negedge clk);
        start = 1'b1; a = W'(8'hC3); b = W'(8'h3C); mode = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        abort = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("abort_result", 64'(result), 64'(keep.res));
        chk("abort_carry", 64'(carry_out), 64'(keep.co));
        chk("abort_ovf", 64'(overflow), 64'(keep.ov));

        // reset mid-operation clears everything at once
        @(negedge clk);
        start = 1'b1; a = W'(8'h77); b = W'(8'h11); mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        chk("mid_rst_carry", 64'(carry_out), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // unit still healthy after reset
        do_op(W'(8'h01), W'(8'h02), 1'b1, 1'b0);
        repeat (W + 4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
Parametrised serial adder/subtractor with an integrated control FSM. It takes two WIDTH-bit operands and processes them one bit per clock, LSB first. Each operation has a start/busy/done handshake and reports carry and signed overflow. It is the next generation of the 8-bit serial full-adder control block, generalised in width, with a subtract mode, an abort, and exact WIDTH-cycle bit counting.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request new operation; sampled only in IDLE
mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
abort  input  1  synchronous cancel of an in-flight operation
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high in LOAD and ADD
done  output  1  one-cycle pulse in FIN
result  output  WIDTH  sum/difference; valid from FIN until the next accepted start
carry_out  output  1  final carry; in subtract mode 1 = no borrow
overflow  output  1  signed overflow of the last completed operation

Behaviour:
- Reset (rst_n=0, async): state=IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, bit counter=0, shift registers=0.
- States are IDLE, LOAD, ADD, FIN (2-bit encoding).
- IDLE:
  - start=1 on an edge captures a, b and mode into internal latches; next state is LOAD.
  - start=0 stays in IDLE.
  - abort has no effect.
- LOAD (1 cycle):
  - A shift register <= a; B shift register <= b XOR {WIDTH{mode}}.
  - Carry flop <= mode; counter <= 0.
  - Next state is ADD.
- ADD (exactly WIDTH cycles):
  - Each edge: sum = A[0]^B[0]^c; c <= majority(A[0],B[0],c).
  - Sum shifts into the result shift register MSB-side; A and B shift right; counter increments.
  - On the edge where counter==WIDTH-1:
    - result register takes its final value.
    - carry_out <= carry out of the MSB.
    - overflow <= carry into MSB XOR carry out of MSB.
    - Next state is FIN.
- FIN (1 cycle): done=1, busy=0; next state is IDLE. start in FIN is ignored.
- Latency: start sampled at edge N → done high during cycle N+WIDTH+2, i.e. after WIDTH+2 edges. Back-to-back throughput is one operation per WIDTH+3 cycles.
- start while busy=1 is ignored. Operand or mode changes after acceptance have no effect.
- abort=1 in LOAD or ADD:
  - Next state is IDLE and the counter clears.
  - No done pulse; result, carry_out and overflow keep their values from the previous completed operation. Result is committed only at the final ADD edge.
  - abort in FIN is ignored, so done still pulses.
  - abort and start together in IDLE: start wins, since abort is a no-op in IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Counter compare uses CNT_W bits, with WIDTH-1 as the terminal count, so there is no off-by-one extra cycle.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state encoding constants ST_IDLE=2'b00, ST_LOAD=2'b01, ST_ADD=2'b10, ST_FIN=2'b11
  - mode constants MODE_ADD=1'b0, MODE_SUB=1'b1
- One natural sub-module: serial_fa_bit. It is a 1-bit full adder plus carry flop, with ports clk, rst_n, init, init_val, en, a, b, sum, cout, cin_q. It is instantiated once; the FSM, counter and shift registers live in the top.

Test Plan:
- WIDTH=8, add 8'h3C+8'h05 → result 8'h41, carry_out 0, overflow 0; done pulses exactly 10 edges after the start edge, one cycle wide; busy high for 9 cycles.
- WIDTH=8, sub 8'h05-8'h07 → result 8'hFE, carry_out 0 (borrow), overflow 0. Then sub 8'h80-8'h01 → result 8'h7F, carry_out 1, overflow 1.
- WIDTH=8, add 8'h7F+8'h01 → 8'h80, overflow 1, carry_out 0. Then add 8'hFF+8'h01 → 8'h00, carry_out 1, overflow 0.
- Hold start=1 continuously with changing a/b → only IDLE samples are accepted; each result matches the operands present at its accept edge; ops run back-to-back every 11 cycles.
- Complete 8'h10+8'h20 (result 8'h30), start a new op, then pulse abort on the 3rd ADD cycle → IDLE next edge, no done, result stays 8'h30. Repeat the interruption using rst_n=0 instead → all outputs 0 immediately.
- WIDTH=16 build: add 16'hFFFF+16'h0001 → 16'h0000, carry_out 1, done after 18 edges. WIDTH=2: sub 2'b01-2'b10 → 2'b11, overflow 1.
